// File: rtl/kbd_input.sv
// rtl/kbd_input.sv - serial keyboard receiver exposing the LC-3 KBSR/KBDR register pair
module kbd_input #(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic        i_Clk,
   input  logic        reset_,
   input  logic        rx_serial,
   input  logic        ld_kbsr,
   input  logic [15:0] kbsr_in,
   input  logic        rd_kbdr,
   output logic [15:0] kbsr,
   output logic [15:0] kbdr,
   output logic        kb_intr
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] CNT_HALF = CW'((CLKS_PER_BIT - 1) / 2);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t          state;
   logic [CW-1:0]   clk_cnt;
   logic [2:0]      bit_idx;
   logic [7:0]      shift_reg;
   logic            rx_meta, rx_s;
   logic            byte_done, frame_bad;
   logic            ready, ie, overrun, frame_err;
   logic [7:0]      data_reg;

   // Two-flop synchronizer; resets to the idle (high) line level.
   always_ff @(posedge i_Clk or negedge reset_) begin
      if (!reset_) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= rx_serial;
         rx_s    <= rx_meta;
      end
   end

   always_ff @(posedge i_Clk or negedge reset_) begin
      if (!reset_) begin
         state     <= IDLE;
         clk_cnt   <= '0;
         bit_idx   <= '0;
         shift_reg <= '0;
         byte_done <= 1'b0;
         frame_bad <= 1'b0;
      end else begin
         byte_done <= 1'b0;
         frame_bad <= 1'b0;
         case (state)
            IDLE: begin
               clk_cnt <= '0;
               bit_idx <= '0;
               if (!rx_s) state <= START;
            end
            START: begin
               if (clk_cnt == CNT_HALF) begin
                  clk_cnt <= '0;
                  bit_idx <= '0;
                  state   <= rx_s ? IDLE : DATA;
               end else begin
                  clk_cnt <= clk_cnt + CW'(1);
               end
            end
            DATA: begin
               if (clk_cnt == CNT_LAST) begin
                  clk_cnt            <= '0;
                  shift_reg[bit_idx] <= rx_s;
                  if (bit_idx == 3'd7) state <= STOP;
                  else                 bit_idx <= bit_idx + 3'd1;
               end else begin
                  clk_cnt <= clk_cnt + CW'(1);
               end
            end
            STOP: begin
               if (clk_cnt == CNT_LAST) begin
                  clk_cnt <= '0;
                  state   <= IDLE;
                  if (rx_s) byte_done <= 1'b1;
                  else      frame_bad <= 1'b1;
               end else begin
                  clk_cnt <= clk_cnt + CW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Flag-setting events take priority over the clearing writes from ld_kbsr and rd_kbdr.
   always_ff @(posedge i_Clk or negedge reset_) begin
      if (!reset_) begin
         ready     <= 1'b0;
         ie        <= 1'b0;
         overrun   <= 1'b0;
         frame_err <= 1'b0;
         data_reg  <= '0;
         kb_intr   <= 1'b0;
      end else begin
         if (byte_done) begin
            data_reg <= shift_reg;
            ready    <= 1'b1;
         end else if (rd_kbdr) begin
            ready <= 1'b0;
         end

         if (byte_done && ready && !rd_kbdr) overrun <= 1'b1;
         else if (ld_kbsr)                   overrun <= overrun & kbsr_in[13];

         if (frame_bad)    frame_err <= 1'b1;
         else if (ld_kbsr) frame_err <= frame_err & kbsr_in[12];

         if (ld_kbsr) ie <= kbsr_in[14];

         kb_intr <= ready & ie;
      end
   end

   assign kbsr = {ready, ie, overrun, frame_err, 12'b0};
   assign kbdr = {8'h00, data_reg};

endmodule

// File: tb/tb_kbd_input.sv
// tb/tb_kbd_input.sv - directed self-checking bench for kbd_input
module tb_kbd_input;

   localparam int BIT = 16;

   logic        clk = 1'b0;
   logic        reset_ = 1'b0;
   logic        rx = 1'b1;
   logic        ld_kbsr = 1'b0;
   logic [15:0] kbsr_in = 16'h0000;
   logic        rd_kbdr = 1'b0;
   logic [15:0] kbsr, kbdr;
   logic        kb_intr;
   int          checks = 0;
   int          failures = 0;
   int          lat;

   kbd_input #(.CLKS_PER_BIT(BIT)) dut (
      .i_Clk     (clk),
      .reset_    (reset_),
      .rx_serial (rx),
      .ld_kbsr   (ld_kbsr),
      .kbsr_in   (kbsr_in),
      .rd_kbdr   (rd_kbdr),
      .kbsr      (kbsr),
      .kbdr      (kbdr),
      .kb_intr   (kb_intr)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge after the stop bit ends.
   task automatic send_frame(input logic [7:0] b, input logic stop_bit);
      rx = 1'b0;
      repeat (BIT) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (BIT) @(negedge clk);
      end
      rx = stop_bit;
      repeat (BIT) @(negedge clk);
      rx = 1'b1;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic ld_write(input logic [15:0] v);
      ld_kbsr = 1'b1;
      kbsr_in = v;
      @(negedge clk);
      ld_kbsr = 1'b0;
      kbsr_in = 16'h0000;
   endtask

   task automatic rd_pulse();
      rd_kbdr = 1'b1;
      @(negedge clk);
      rd_kbdr = 1'b0;
   endtask

   initial begin
      idle(3);
      check("rst_kbsr", kbsr, 16'h0000);
      check("rst_kbdr", kbdr, 16'h0000);
      check("rst_intr", {15'b0, kb_intr}, 16'h0000);
      reset_ = 1'b1;
      idle(5);

      // 0x41: nothing visible before the stop sample, ready within the frame budget
      lat = 0;
      fork
         send_frame(8'h41, 1'b1);
         begin
            repeat (9 * BIT) @(negedge clk);
            check("pre_stop_kbsr", kbsr, 16'h0000);
         end
         begin
            while (!kbsr[15] && lat < 300) begin
               @(negedge clk);
               lat++;
            end
         end
      join
      check("lat_in_window", {15'b0, (lat > 9 * BIT && lat <= 158)}, 16'h0001);
      check("rx41_kbdr", kbdr, 16'h0041);
      check("rx41_kbsr", kbsr, 16'h8000);
      idle(10);

      rd_pulse();
      check("rd_clears", kbsr, 16'h0000);
      ld_write(16'h4000);
      check("ie_set", kbsr, 16'h4000);

      // 0x5A with interrupts enabled: kb_intr lags ready by one clock
      fork
         send_frame(8'h5A, 1'b1);
         begin
            for (int i = 0; i < 300 && !kbsr[15]; i++) @(negedge clk);
            check("intr_lag0", {15'b0, kb_intr}, 16'h0000);
            @(negedge clk);
            check("intr_lag1", {15'b0, kb_intr}, 16'h0001);
         end
      join
      check("rx5a_kbsr", kbsr, 16'hC000);
      check("rx5a_kbdr", kbdr, 16'h005A);
      idle(10);
      rd_pulse();
      check("rd5a_kbsr", kbsr, 16'h4000);
      @(negedge clk);
      check("rd5a_intr", {15'b0, kb_intr}, 16'h0000);
      check("rd5a_kbdr", kbdr, 16'h005A);

      // Overrun
      ld_write(16'h0000);
      send_frame(8'h31, 1'b1);
      idle(6);
      send_frame(8'h32, 1'b1);
      idle(6);
      check("ovr_kbdr", kbdr, 16'h0032);
      check("ovr_kbsr", kbsr, 16'hA000);
      ld_write(16'h0000);
      check("ovr_clear", kbsr, 16'h8000);

      // Framing error leaves data and ready alone
      rd_pulse();
      send_frame(8'h55, 1'b0);
      idle(30);
      check("frm_kbdr", kbdr, 16'h0032);
      check("frm_kbsr", kbsr, 16'h1000);
      ld_write(16'h0000);
      check("frm_clear", kbsr, 16'h0000);

      // Short glitch on the idle line
      rx = 1'b0;
      idle(4);
      rx = 1'b1;
      idle(40);
      check("glitch_kbsr", kbsr, 16'h0000);
      check("glitch_kbdr", kbdr, 16'h0032);
      send_frame(8'h20, 1'b1);
      idle(6);
      check("post_glitch_kbdr", kbdr, 16'h0020);
      check("post_glitch_kbsr", kbsr, 16'h8000);

      // rd_kbdr coincides with byte_done of 0x7E
      fork
         send_frame(8'h7E, 1'b1);
         begin
            repeat (155) @(negedge clk);
            rd_kbdr = 1'b1;
            @(negedge clk);
            rd_kbdr = 1'b0;
         end
      join
      idle(4);
      check("coll_kbdr", kbdr, 16'h007E);
      check("coll_kbsr", kbsr, 16'h8000);

      // Reset during data bit 3, then a clean 0x0D
      rx = 1'b0;
      idle(BIT);
      rx = 1'b1; idle(BIT);
      rx = 1'b0; idle(BIT);
      rx = 1'b1; idle(BIT);
      rx = 1'b1; idle(BIT / 2);
      #2 reset_ = 1'b0;
      #1;
      check("arst_kbsr", kbsr, 16'h0000);
      check("arst_kbdr", kbdr, 16'h0000);
      check("arst_intr", {15'b0, kb_intr}, 16'h0000);
      idle(3);
      reset_ = 1'b1;
      idle(12 * BIT);
      check("post_rst_kbsr", kbsr, 16'h0000);
      check("post_rst_kbdr", kbdr, 16'h0000);
      send_frame(8'h0D, 1'b1);
      idle(6);
      check("rx0d_kbdr", kbdr, 16'h000D);
      check("rx0d_kbsr", kbsr, 16'h8000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/kbd_input.md
# kbd_input

Keyboard input stage for the LC-3 core: deserializes the board's serial receive line (RsRx) and presents the received character to the datapath as the memory-mapped KBSR/KBDR register pair. It is the input-side counterpart of the display path (DSR/DDR into the UART transmitter). It sits between the RsRx pin and the DATAPATH memory-mapped I/O read mux; the FSM's ld_kbsr drives KBSR writes.

## Interface
- CLKS_PER_BIT, 434, i_Clk cycles per serial bit (50 MHz / 115200 baud); minimum 4.
- i_Clk  input  1  system clock; all state updates on rising edge.
- reset_  input  1  asynchronous, active-low reset.
- rx_serial  input  1  raw serial line, idle high, asynchronous to i_Clk.
- ld_kbsr  input  1  FSM strobe: write KBSR from kbsr_in this cycle.
- kbsr_in  input  16  bus value for KBSR write; only bits 14, 13 and 12 are used.
- rd_kbdr  input  1  one-cycle strobe when the datapath reads KBDR; clears ready.
- kbsr  output  16  {ready, ie, overrun, frame_err, 12'b0}.
- kbdr  output  16  {8'h00, last received byte}.
- kb_intr  output  1  kbsr[15] & kbsr[14], registered.

## Operation
- Input sync: rx_serial passes through two flops (rx_s); the reset value of both flops is 1. All decisions use rx_s.
- Receiver FSM states: IDLE, START, DATA, STOP. A counter clk_cnt counts 0..CLKS_PER_BIT-1, and bit_idx counts 0..7.
  - IDLE: when rx_s = 0, go to START with clk_cnt = 0.
  - START: when clk_cnt = (CLKS_PER_BIT-1)/2 (integer), sample rx_s. If it is 0, go to DATA with clk_cnt = 0 and bit_idx = 0. If it is 1 (glitch), go to IDLE with no flag change.
  - DATA: when clk_cnt = CLKS_PER_BIT-1, shift rx_s into shift_reg (LSB first: bit_idx n goes to shift_reg[n]) and clear clk_cnt. After bit_idx 7, go to STOP; otherwise increment bit_idx.
  - STOP: when clk_cnt = CLKS_PER_BIT-1, sample rx_s and go to IDLE.
    - If rx_s = 1: assert the internal byte_done strobe for one cycle.
    - If rx_s = 0: set frame_err, discard the byte, and leave kbdr and ready unchanged.
- On byte_done:
  - kbdr[7:0] <= shift_reg.
  - If ready is already 1 and rd_kbdr is not asserted the same cycle, set overrun (new byte still overwrites kbdr).
  - Set ready to 1.
- rd_kbdr clears ready. byte_done in the same cycle takes priority: ready stays 1, kbdr takes the new byte, overrun is not set.
- ld_kbsr writes:
  - ie <= kbsr_in[14].
  - overrun <= overrun & kbsr_in[13] (write 0 to clear).
  - frame_err <= frame_err & kbsr_in[12].
  - ready is read-only to ld_kbsr.
  - If a flag-setting event coincides with ld_kbsr, the set wins.
- kbdr[15:8] is always 0. kbsr[11:0] is always 0.

## Timing
- Reset (asynchronous, reset_ = 0):
  - Outputs: kbsr = 16'h0000, kbdr = 16'h0000, kb_intr = 0.
  - Internal: FSM = IDLE, clk_cnt = 0, bit_idx = 0, shift_reg = 0, sync flops = 1.
  - Reset mid-frame aborts the frame with no flag or data change after release. The receiver resynchronizes on the next falling edge seen in IDLE.
- Latency: the rx_serial falling edge reaches rx_s after 2 clocks.
- Start-bit midpoint sample: 2 + (CLKS_PER_BIT-1)/2 clocks after the edge.
- Each data bit is sampled CLKS_PER_BIT clocks after the previous sample.
- kbsr[15] and kbdr update on the clock edge after the stop-bit sample. kb_intr follows one clock later.
- Total from start-edge to ready is roughly 9.5 × CLKS_PER_BIT + 3 clocks.
- Back-to-back frames: IDLE is entered the cycle after the stop sample, so a start bit beginning half a bit after the stop midpoint is captured. There is no dead time beyond that.
- rd_kbdr and ld_kbsr are single-cycle strobes. Holding either high for N cycles behaves as N strobes.

## Test plan
- Byte receive: CLKS_PER_BIT=16; drive 0x41 at 16 clk/bit (start, 1,0,0,0,0,0,1,0, stop) -> kbdr=16'h0041 and kbsr=16'h8000 within 9.5×16+3 clocks; no change before the stop sample.
- Read and interrupt:
  - ld_kbsr with kbsr_in=16'h4000, then receive 0x5A -> kbsr=16'hC000 and kb_intr=1 one clock after ready.
  - Pulse rd_kbdr -> kbsr=16'h4000 and kb_intr=0 next clock; kbdr stays 16'h005A.
- Overrun: receive 0x31, then 0x32 without rd_kbdr -> kbdr=16'h0032, kbsr=16'hA000. ld_kbsr with 16'h0000 -> kbsr=16'h8000.
- Framing and glitch:
  - Frame 0x55 with stop bit 0 -> kbdr unchanged, kbsr=16'h1000.
  - A low pulse of 4 clocks on idle line -> no state change; FSM returns to IDLE.
- Collision: align rd_kbdr with the byte_done cycle of a second byte 0x7E while ready=1 -> kbdr=16'h007E, kbsr[15]=1, kbsr[13]=0.
- Reset mid-frame: assert reset_=0 during data bit 3 -> all outputs 0 immediately (asynchronously). After release, a fresh 0x0D frame is received correctly.
